// File: rtl/lc3_io_read_mux.sv
// LC-3 read-path source selector: accepts a read request, waits for the chosen
// source to become ready (bounded by a timeout), and returns registered data.
module lc3_io_read_mux #(
   parameter int WIDTH   = 16,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [SEL_W-1:0]         req_sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic [NUM_SRC-1:0]       src_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     rsp_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   w_next_sel;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_next_cnt;
   logic [WIDTH-1:0]   r_rsp_data;
   logic [WIDTH-1:0]   w_next_data;
   logic               r_rsp_err;
   logic               w_next_err;

   logic [WIDTH-1:0]   w_sel_data;
   logic               w_sel_ready;
   logic               w_req_bad;
   logic               w_timeout_hit;

   // Loop compare rather than a variable slice, so unused select codes
   // (when NUM_SRC < 2**SEL_W) never index past the source vector.
   always_comb begin
      w_sel_data  = '0;
      w_sel_ready = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (r_sel == SEL_W'(i)) begin
            w_sel_data  = src_data[i*WIDTH +: WIDTH];
            w_sel_ready = src_ready[i];
         end
      end
   end

   assign w_req_bad     = (32'(req_sel) >= 32'(NUM_SRC));
   assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_next_sel   = r_sel;
      w_next_cnt   = r_cnt;
      w_next_data  = r_rsp_data;
      w_next_err   = r_rsp_err;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_next_sel = req_sel;
               if (w_req_bad) begin
                  w_next_data  = '0;
                  w_next_err   = 1'b1;
                  w_next_state = ST_RESP;
               end else begin
                  w_next_cnt   = '0;
                  w_next_state = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // Ready wins over timeout when both land on the same edge.
            if (w_sel_ready) begin
               w_next_data  = w_sel_data;
               w_next_err   = 1'b0;
               w_next_state = ST_RESP;
            end else if (w_timeout_hit) begin
               w_next_data  = '0;
               w_next_err   = 1'b1;
               w_next_state = ST_RESP;
            end else begin
               w_next_cnt = r_cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_cnt      <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_sel      <= w_next_sel;
         r_cnt      <= w_next_cnt;
         r_rsp_data <= w_next_data;
         r_rsp_err  <= w_next_err;
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lc3_io_read_mux.sv
// Bench for lc3_io_read_mux: table vectors, reset corner sequences and random
// transactions against a latency/result model, on NUM_SRC=4 and NUM_SRC=3 copies.
module tb_lc3_io_read_mux;

   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_valid;
   logic               rsp_ready;
   logic               use3;
   logic [1:0]         req_sel;
   logic [4*WIDTH-1:0] src_data;
   logic [3:0]         src_ready;

   logic               req_ready4, rsp_valid4, rsp_err4;
   logic [WIDTH-1:0]   rsp_data4;
   logic               req_ready3, rsp_valid3, rsp_err3;
   logic [WIDTH-1:0]   rsp_data3;

   logic               o_req_ready, o_rsp_valid, o_rsp_err;
   logic [WIDTH-1:0]   o_rsp_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lc3_io_read_mux #(.WIDTH(WIDTH), .NUM_SRC(4), .SEL_W(2), .TIMEOUT(TIMEOUT), .CNT_W(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid & ~use3),
      .req_ready (req_ready4),
      .req_sel   (req_sel),
      .src_data  (src_data),
      .src_ready (src_ready),
      .rsp_valid (rsp_valid4),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data4),
      .rsp_err   (rsp_err4)
   );

   lc3_io_read_mux #(.WIDTH(WIDTH), .NUM_SRC(3), .SEL_W(2), .TIMEOUT(TIMEOUT), .CNT_W(4)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid & use3),
      .req_ready (req_ready3),
      .req_sel   (req_sel),
      .src_data  (src_data[3*WIDTH-1:0]),
      .src_ready (src_ready[2:0]),
      .rsp_valid (rsp_valid3),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data3),
      .rsp_err   (rsp_err3)
   );

   assign o_req_ready = use3 ? req_ready3 : req_ready4;
   assign o_rsp_valid = use3 ? rsp_valid3 : rsp_valid4;
   assign o_rsp_err   = use3 ? rsp_err3   : rsp_err4;
   assign o_rsp_data  = use3 ? rsp_data3  : rsp_data4;

   typedef struct {
      bit          u3;
      int          sel;
      int          delay;
      logic [15:0] data;
      int          hold;
      int          exp_lat;
      logic        exp_err;
      logic [15:0] exp_data;
   } vec_t;

   typedef struct {
      int          lat;
      logic        err;
      logic [15:0] data;
   } exp_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Latency is counted in edges from the acceptance edge (edge 1):
   // bad select -> 1, ready after d low WAIT cycles -> 2+d, timeout -> 1+TIMEOUT.
   function automatic exp_t model(input int nsrc, input int sel, input int delay, input logic [15:0] data);
      exp_t e;
      if (sel >= nsrc) begin
         e.lat = 1; e.err = 1'b1; e.data = 16'h0000;
      end else if (TIMEOUT != 0 && delay >= TIMEOUT) begin
         e.lat = 1 + TIMEOUT; e.err = 1'b1; e.data = 16'h0000;
      end else begin
         e.lat = 2 + delay; e.err = 1'b0; e.data = data;
      end
      return e;
   endfunction

   function automatic logic rdy_for_edge(input int e, input int delay);
      return (delay == 0) ? 1'b1 : (e >= 2 + delay);
   endfunction

   task automatic set_slice(input int idx, input logic [15:0] v);
      src_data[idx*WIDTH +: WIDTH] = v;
   endtask

   task automatic rst_pulse(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_txn(input bit u3, input int sel, input int delay, input logic [15:0] data,
                          input int hold, input bit release_rsp, input int exp_lat,
                          input logic exp_err, input logic [15:0] exp_data, input string tag);
      int lat;
      lat = 0;
      @(negedge clk);
      use3 = u3;
      #1;
      check({tag, "_req_ready"}, o_req_ready, 1);
      src_data  = {$urandom, $urandom};
      set_slice(sel, data);
      src_ready = 4'($urandom);
      src_ready[sel] = rdy_for_edge(1, delay);
      req_sel   = 2'(sel);
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      for (int e = 1; e <= 40 && lat == 0; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (o_rsp_valid) lat = e;
         req_valid = (lat == 0 && e > 1) ? 1'($urandom) : 1'b0;
         req_sel   = 2'($urandom);
         src_data  = {$urandom, $urandom};
         set_slice(sel, data);
         src_ready = 4'($urandom);
         src_ready[sel] = rdy_for_edge(e + 1, delay);
      end
      req_valid = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      if (lat == 0) begin
         rst_pulse(1);
         return;
      end
      check({tag, "_err"}, o_rsp_err, exp_err);
      check({tag, "_data"}, o_rsp_data, exp_data);
      for (int h = 0; h < hold; h++) begin
         set_slice(sel, ~data);
         src_ready = 4'($urandom);
         @(posedge clk);
         @(negedge clk);
         check({tag, "_hold_valid"}, o_rsp_valid, 1);
         check({tag, "_hold_data"}, o_rsp_data, exp_data);
         check({tag, "_hold_err"}, o_rsp_err, exp_err);
      end
      if (release_rsp) begin
         rsp_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rsp_ready = 1'b0;
         check({tag, "_rel_valid"}, o_rsp_valid, 0);
         check({tag, "_rel_req_ready"}, o_req_ready, 1);
         check({tag, "_rel_data_kept"}, o_rsp_data, exp_data);
      end
   endtask

   vec_t vecs[7];

   initial begin
      int   seen;
      exp_t e;
      bit   u3;
      int   sel, delay, hold;
      logic [15:0] data;

      vecs[0] = '{1'b0, 2, 0,  16'hBEEF, 5, 2,  1'b0, 16'hBEEF};
      vecs[1] = '{1'b0, 3, 4,  16'h1234, 2, 6,  1'b0, 16'h1234};
      vecs[2] = '{1'b0, 1, 15, 16'hAAAA, 1, 16, 1'b1, 16'h0000};
      vecs[3] = '{1'b0, 1, 14, 16'h5A5A, 0, 16, 1'b0, 16'h5A5A};
      vecs[4] = '{1'b1, 3, 0,  16'h7777, 2, 1,  1'b1, 16'h0000};
      vecs[5] = '{1'b1, 2, 1,  16'hC0DE, 1, 3,  1'b0, 16'hC0DE};
      vecs[6] = '{1'b0, 0, 0,  16'h0001, 0, 2,  1'b0, 16'h0001};

      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; use3 = 1'b0;
      req_sel = '0; src_data = '0; src_ready = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("reset_valid4", rsp_valid4, 0);
      check("reset_data4", rsp_data4, 0);
      check("reset_err4", rsp_err4, 0);
      check("reset_req_ready4", req_ready4, 1);
      check("reset_valid3", rsp_valid3, 0);
      check("reset_req_ready3", req_ready3, 1);

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i].u3, vecs[i].sel, vecs[i].delay, vecs[i].data, vecs[i].hold, 1'b1,
                 vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_data, $sformatf("vec%0d", i));
      end

      // Reset while waiting on a source that never becomes ready.
      @(negedge clk);
      use3 = 1'b0; req_sel = 2'd1; src_ready = 4'b0000; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      rst_pulse(1);
      check("rst_wait_valid", rsp_valid4, 0);
      check("rst_wait_req_ready", req_ready4, 1);
      check("rst_wait_data", rsp_data4, 0);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid4) seen++;
      end
      check("rst_wait_no_rsp", seen, 0);
      run_txn(1'b0, 0, 0, 16'h0F0F, 0, 1'b1, 2, 1'b0, 16'h0F0F, "after_rst_wait");

      // Reset while a response is pending and unconsumed.
      run_txn(1'b0, 2, 1, 16'hFACE, 1, 1'b0, 3, 1'b0, 16'hFACE, "rsp_pending");
      rst_pulse(1);
      check("rst_resp_valid", rsp_valid4, 0);
      check("rst_resp_req_ready", req_ready4, 1);
      check("rst_resp_data", rsp_data4, 0);
      check("rst_resp_err", rsp_err4, 0);
      run_txn(1'b0, 0, 2, 16'h3C3C, 0, 1'b1, 4, 1'b0, 16'h3C3C, "after_rst_resp");

      for (int r = 0; r < 24; r++) begin
         u3    = ($urandom_range(0, 3) == 0);
         sel   = $urandom_range(0, 3);
         delay = $urandom_range(0, 18);
         data  = 16'($urandom);
         hold  = $urandom_range(0, 2);
         e     = model(u3 ? 3 : 4, sel, delay, data);
         run_txn(u3, sel, delay, data, hold, 1'b1, e.lat, e.err, e.data, $sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
